exception_ctrl: RTL
===================

# exception_ctrl

Trap sequencer feeding the CP0 register block. It watches decode-stage exception sources and the external interrupt line. When a trap is taken, it drives `cause_write`/`int_cause` into CP0, flushes the front of the pipeline and redirects fetch to the handler. On `eret` it drives `exit_kernel` and redirects fetch to the saved EPC.

## Interface
Parameters:
- `HANDLER_ADDR`, default 32'h0000_0080: fetch address of the common trap handler.
- `FAULT_CNT_W`, default 8: width of the kernel-fault counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `irq` in 1: external interrupt request, level. Held by the source until `irq_ack`.
- `syscall_D` in 1: syscall instruction in decode.
- `illegal_D` in 1: unknown opcode in decode.
- `eret_D` in 1: return-from-exception in decode.
- `stallD` in 1: decode stalled; no D-stage event is accepted while high.
- `epc` in 32: EPC value read from CP0.
- `int_cause` out 3: cause code to CP0. 001 = irq, 010 = syscall, 011 = illegal, 000 = none.
- `cause_write` out 1: one-cycle pulse that writes cause/EPC and enters kernel mode in CP0.
- `exit_kernel` out 1: one-cycle pulse that returns CP0 to user mode.
- `flush_FDE` out 1: flush the F, D and E pipeline registers.
- `pc_redirect` out 1: fetch takes `pc_target` next cycle.
- `pc_target` out 32: redirect address.
- `irq_ack` out 1: one-cycle acknowledge to the interrupt source.
- `kern_fault_cnt` out FAULT_CNT_W: count of syscall/illegal events seen in kernel mode.

## Operation
- States: KERNEL, ENTER, USER, RETURN.
- Reset state is KERNEL. The CPU boots in kernel mode, matching CP0.
- **USER**
  - The state latches the highest-priority accepted event and moves to ENTER.
  - Priority: illegal (011) > syscall (010) > irq (001).
  - D-stage events are accepted only when `stallD`=0.
  - irq is accepted only when `irq_s`=1 and `irq_armed`=1.
- **ENTER** (one cycle)
  - Outputs: `cause_write`=1, `int_cause`=latched code, `flush_FDE`=1, `pc_redirect`=1, `pc_target`=HANDLER_ADDR.
  - If the cause is irq, `irq_ack`=1 and `irq_armed` is cleared.
  - Next state is KERNEL.
- **KERNEL**
  - Traps are masked; irq stays pending.
  - `syscall_D` or `illegal_D` with `stallD`=0 increments `kern_fault_cnt`, saturating at all-ones. No trap is taken.
  - `eret_D` with `stallD`=0 moves to RETURN. eret takes precedence over a simultaneous fault; the fault is not counted.
- **RETURN** (one cycle)
  - Outputs: `exit_kernel`=1, `flush_FDE`=1, `pc_redirect`=1, `pc_target`=`epc`, sampled that cycle.
  - Next state is USER.
- **eret in USER**: treated as illegal (code 011).
- **irq re-arm**: `irq_armed` sets when `irq_s`=0. Reset value is 1. This prevents a held line from re-trapping after ack.
- **Outputs**: `int_cause` is 000 and all pulse outputs are 0 in every state except those listed above. `pc_target` is 0 when `pc_redirect`=0.

## Timing
- All state, `irq_armed`, the latched cause and the counter are registered. Outputs are decoded from the registered state.
- Event sampled at edge N (state USER) → ENTER during cycle N+1 → KERNEL from N+2. Handler fetch is issued in N+2.
- `eret_D` sampled at edge N in KERNEL → RETURN during N+1 → USER from N+2.
- irq latency from `irq` rising to ENTER: 3 cycles with the synchroniser, 1 cycle without.
- Events arriving while in ENTER or RETURN are ignored. Decode is being flushed in those cycles.
- Reset mid-operation, asynchronous:
  - State → KERNEL, `irq_armed`=1, latched cause=000, `kern_fault_cnt`=0.
  - All outputs go to 0 immediately, including any pulse in progress.
  - The synchroniser flops clear to 0.

## Configuration
- `EXC_IRQ_SYNC_EN` defined: `irq` passes through a two-flop synchroniser; `irq_s` is the second flop.
- Not defined: `irq_s` = `irq` directly, for a source already in the `clk` domain.
- Everything else is identical in both builds.

## Test plan
- **Reset boot:** assert `reset` → all outputs 0, `kern_fault_cnt`=0. `eret_D`=1 one cycle → RETURN: `exit_kernel`=1, `pc_target`=`epc`=32'h0000_1000, then USER.
- **Syscall:** in USER, `syscall_D`=1, `stallD`=0 → next cycle `cause_write`=1, `int_cause`=010, `flush_FDE`=1, `pc_target`=32'h0000_0080. State is KERNEL afterwards.
- **Priority:** in USER, `illegal_D`=1, `syscall_D`=1 and `irq` high, all together → `int_cause`=011. `irq_ack` stays 0; irq remains pending. After eret, irq trap fires with `int_cause`=001 and `irq_ack`=1.
- **Held irq:** `irq` held high across ENTER/KERNEL/eret → no second irq trap in USER. Drop `irq` for ≥1 cycle (plus sync delay), raise again → new trap.
- **Stall and kernel faults:**
  - `syscall_D`=1 with `stallD`=1 in USER → no trap.
  - In KERNEL, 300 `illegal_D` pulses → `kern_fault_cnt`=255 (saturated).
- **Reset mid-ENTER:** assert `reset` during ENTER → `cause_write` drops the same cycle. After release, state is KERNEL and `irq_armed`=1.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// Trap-sequencer bus: decode-stage exception sources and irq in, CP0/fetch controls out.
// slave = exception_ctrl side, master = pipeline/CP0 side.
interface exception_ctrl_if #(
    parameter int FAULT_CNT_W = 8
);
    logic                   irq;
    logic                   syscall_D;
    logic                   illegal_D;
    logic                   eret_D;
    logic                   stallD;
    logic [31:0]            epc;
    logic [2:0]             int_cause;
    logic                   cause_write;
    logic                   exit_kernel;
    logic                   flush_FDE;
    logic                   pc_redirect;
    logic [31:0]            pc_target;
    logic                   irq_ack;
    logic [FAULT_CNT_W-1:0] kern_fault_cnt;

    modport slave (
        input  irq, syscall_D, illegal_D, eret_D, stallD, epc,
        output int_cause, cause_write, exit_kernel, flush_FDE, pc_redirect,
               pc_target, irq_ack, kern_fault_cnt
    );

    modport master (
        output irq, syscall_D, illegal_D, eret_D, stallD, epc,
        input  int_cause, cause_write, exit_kernel, flush_FDE, pc_redirect,
               pc_target, irq_ack, kern_fault_cnt
    );
endinterface

// File: rtl/exception_ctrl.sv
// Trap sequencer: takes exceptions/irq into the handler, returns on eret, counts kernel faults.
// Define EXC_IRQ_SYNC_EN to pass irq through a two-flop synchroniser.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          FAULT_CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    exception_ctrl_if.slave  exc
);
    typedef enum logic [1:0] {KERNEL, ENTER, USER, RETURN} state_t;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_IRQ  = 3'b001;
    localparam logic [2:0] C_SYS  = 3'b010;
    localparam logic [2:0] C_ILL  = 3'b011;

    logic irq_s;

`ifdef EXC_IRQ_SYNC_EN
    logic irq_m, irq_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_m <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            irq_m <= exc.irq;
            irq_q <= irq_m;
        end
    end
    assign irq_s = irq_q;
`else
    assign irq_s = exc.irq;
`endif

    state_t                 state_q, state_d;
    logic [2:0]             cause_q, cause_d;
    logic                   irq_armed;
    logic [FAULT_CNT_W-1:0] cnt_q;
    logic                   cnt_inc;
    logic                   d_ok;

    logic [2:0]  int_cause;
    logic        cause_write, exit_kernel, flush_FDE, pc_redirect, irq_ack;
    logic [31:0] pc_target;

    assign d_ok = ~exc.stallD;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        cnt_inc     = 1'b0;
        int_cause   = C_NONE;
        cause_write = 1'b0;
        exit_kernel = 1'b0;
        flush_FDE   = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 32'h0;
        irq_ack     = 1'b0;
        case (state_q)
            USER: begin
                // eret outside the kernel is just another illegal instruction
                if (d_ok && (exc.illegal_D || exc.eret_D)) begin
                    cause_d = C_ILL;
                    state_d = ENTER;
                end else if (d_ok && exc.syscall_D) begin
                    cause_d = C_SYS;
                    state_d = ENTER;
                end else if (irq_s && irq_armed) begin
                    cause_d = C_IRQ;
                    state_d = ENTER;
                end
            end
            ENTER: begin
                cause_write = 1'b1;
                int_cause   = cause_q;
                flush_FDE   = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = HANDLER_ADDR;
                irq_ack     = (cause_q == C_IRQ);
                state_d     = KERNEL;
            end
            KERNEL: begin
                if (d_ok && exc.eret_D)
                    state_d = RETURN;
                else if (d_ok && (exc.syscall_D || exc.illegal_D))
                    cnt_inc = ~&cnt_q;
            end
            RETURN: begin
                exit_kernel = 1'b1;
                flush_FDE   = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = exc.epc;
                state_d     = USER;
            end
            default: state_d = KERNEL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= KERNEL;
            cause_q   <= C_NONE;
            irq_armed <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            // a still-high line after ack must drop before it can trap again
            if (irq_ack)
                irq_armed <= 1'b0;
            else if (!irq_s)
                irq_armed <= 1'b1;
            if (cnt_inc)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign exc.int_cause      = int_cause;
    assign exc.cause_write    = cause_write;
    assign exc.exit_kernel    = exit_kernel;
    assign exc.flush_FDE      = flush_FDE;
    assign exc.pc_redirect    = pc_redirect;
    assign exc.pc_target      = pc_target;
    assign exc.irq_ack        = irq_ack;
    assign exc.kern_fault_cnt = cnt_q;
endmodule
